// File: rtl/spi_pkg.sv
// Frame format shared between the SPI slave and the devices that consume its frames.
// The top two frame bits select the command and the low byte is its payload.
package spi_pkg;
    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;
endpackage

// File: rtl/spi_ram_mem.sv
// Synchronous single-port byte array with a registered read port.
// The array contents are never reset. Only the read register is cleared on reset.
module spi_ram_mem import spi_pkg::*; #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // The read register holds its value between reads and serves as the block's dout.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/spi_ram.sv
// Byte RAM driven by 10-bit SPI slave frames.
// It holds independent write and read address registers and returns read data with a one-cycle strobe.
module spi_ram import spi_pkg::*; #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [FRAME_W-1:0] din,
    output logic [DATA_W-1:0]  dout,
    output logic               tx_valid
);
    cmd_e                 cmd;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] mem_addr;

    assign cmd     = cmd_e'(din[FRAME_W-1:FRAME_W-2]);
    // Reset wins over any command in the same cycle, so gate both strobes with rst.
    assign wr_fire = rx_valid && !rst && (cmd == CMD_WR_DATA);
    assign rd_fire = rx_valid && !rst && (cmd == CMD_RD_DATA);
    assign mem_addr = rd_fire ? rd_addr : wr_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= rd_fire;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
                    CMD_WR_DATA: if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_SIZE'(1);
                    CMD_RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
                    CMD_RD_DATA: if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_SIZE'(1);
                    default: ;
                endcase
            end
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_fire),
        .re   (rd_fire),
        .addr (mem_addr),
        .wdata(din[DATA_W-1:0]),
        .rdata(dout)
    );
endmodule
